// File: rtl/rob_commit.sv
// In-order reorder buffer with single-entry retirement per cycle.
// Optional ROB_RETIRE_COUNT_EN adds a 32-bit retired-commit counter.
module rob_commit #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             alloc_valid,
  input  logic             alloc_regwrite,
  input  logic [4:0]       alloc_arch,
  input  logic [5:0]       alloc_new_phys,
  input  logic [5:0]       alloc_old_phys,
  input  logic [31:0]      alloc_pc,
  input  logic             alloc_sys,
  output logic [PTR_W-1:0] alloc_tag,
  output logic             rob_halt,
  input  logic             complete_valid,
  input  logic [PTR_W-1:0] complete_tag,
  output logic             commit_valid,
  output logic             commit_regwrite,
  output logic [4:0]       commit_arch,
  output logic [5:0]       commit_phys,
  output logic [31:0]      commit_pc,
  output logic             commit_sys,
  output logic             free_valid,
  output logic [5:0]       free_phys,
`ifdef ROB_RETIRE_COUNT_EN
  output logic [31:0]      retired,
`endif
  output logic [PTR_W:0]   count
);

  typedef struct packed {
    logic        regwrite;
    logic [4:0]  arch;
    logic [5:0]  new_phys;
    logic [5:0]  old_phys;
    logic [31:0] pc;
    logic        sys;
  } entry_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  entry_t             mem [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic [DEPTH-1:0]   done;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic               alloc_ok;
  logic               commit_ok;
  entry_t             head_ent;

  assign rob_halt  = (count == FULL);
  assign alloc_tag = tail;

  // Accept/retire decisions; flush suppresses both.
  always_comb begin
    alloc_ok  = alloc_valid & ~rob_halt & ~FLUSH;
    commit_ok = valid[head] & done[head] & ~FLUSH;
    head_ent  = mem[head];
  end

  // Entry payload storage, written at tail on allocation.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (alloc_ok) begin
      mem[tail] <= '{alloc_regwrite, alloc_arch, alloc_new_phys,
                     alloc_old_phys, alloc_pc, alloc_sys};
    end
  end

  // Valid/done bits; allocation overrides a same-slot retire.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid <= '0;
      done  <= '0;
    end else if (FLUSH) begin
      valid <= '0;
      done  <= '0;
    end else begin
      if (complete_valid && valid[complete_tag])
        done[complete_tag] <= 1'b1;
      if (commit_ok) begin
        valid[head] <= 1'b0;
        done[head]  <= 1'b0;
      end
      if (alloc_ok) begin
        valid[tail] <= 1'b1;
        done[tail]  <= 1'b0;
      end
    end
  end

  // Head/tail pointers and occupancy.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (FLUSH) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(commit_ok);
      tail  <= tail + PTR_W'(alloc_ok);
      count <= count + (PTR_W+1)'(alloc_ok)
                     - (PTR_W+1)'(commit_ok);
    end
  end

  // Registered commit and free-list outputs; payload holds when idle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      commit_valid    <= 1'b0;
      commit_regwrite <= 1'b0;
      commit_arch     <= '0;
      commit_phys     <= '0;
      commit_pc       <= '0;
      commit_sys      <= 1'b0;
      free_valid      <= 1'b0;
      free_phys       <= '0;
    end else begin
      commit_valid <= commit_ok;
      free_valid   <= commit_ok & head_ent.regwrite
                    & (head_ent.arch != 5'd0);
      if (commit_ok) begin
        commit_regwrite <= head_ent.regwrite;
        commit_arch     <= head_ent.arch;
        commit_phys     <= head_ent.new_phys;
        commit_pc       <= head_ent.pc;
        commit_sys      <= head_ent.sys;
        free_phys       <= head_ent.old_phys;
      end
    end
  end

`ifdef ROB_RETIRE_COUNT_EN
  // Lifetime commit counter; survives flush, wraps naturally.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      retired <= '0;
    else if (commit_ok)
      retired <= retired + 32'd1;
  end
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit.
// Inputs driven and outputs sampled 1ns after the rising edge.
module tb_rob_commit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        FLUSH = 1'b0;
  logic        alloc_valid = 1'b0;
  logic        alloc_regwrite = 1'b0;
  logic [4:0]  alloc_arch = '0;
  logic [5:0]  alloc_new_phys = '0;
  logic [5:0]  alloc_old_phys = '0;
  logic [31:0] alloc_pc = '0;
  logic        alloc_sys = 1'b0;
  logic [3:0]  alloc_tag;
  logic        rob_halt;
  logic        complete_valid = 1'b0;
  logic [3:0]  complete_tag = '0;
  logic        commit_valid;
  logic        commit_regwrite;
  logic [4:0]  commit_arch;
  logic [5:0]  commit_phys;
  logic [31:0] commit_pc;
  logic        commit_sys;
  logic        free_valid;
  logic [5:0]  free_phys;
  logic [4:0]  count;
`ifdef ROB_RETIRE_COUNT_EN
  logic [31:0] retired;
`endif

  int checks = 0;
  int failures = 0;

  rob_commit #(.DEPTH(16), .PTR_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .alloc_valid(alloc_valid),
    .alloc_regwrite(alloc_regwrite),
    .alloc_arch(alloc_arch),
    .alloc_new_phys(alloc_new_phys),
    .alloc_old_phys(alloc_old_phys),
    .alloc_pc(alloc_pc),
    .alloc_sys(alloc_sys),
    .alloc_tag(alloc_tag),
    .rob_halt(rob_halt),
    .complete_valid(complete_valid),
    .complete_tag(complete_tag),
    .commit_valid(commit_valid),
    .commit_regwrite(commit_regwrite),
    .commit_arch(commit_arch),
    .commit_phys(commit_phys),
    .commit_pc(commit_pc),
    .commit_sys(commit_sys),
    .free_valid(free_valid),
    .free_phys(free_phys),
`ifdef ROB_RETIRE_COUNT_EN
    .retired(retired),
`endif
    .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_alloc(input logic rw, input logic [4:0] a,
                           input logic [5:0] np, input logic [5:0] op,
                           input logic [31:0] pc, input logic sys);
    alloc_valid    = 1'b1;
    alloc_regwrite = rw;
    alloc_arch     = a;
    alloc_new_phys = np;
    alloc_old_phys = op;
    alloc_pc       = pc;
    alloc_sys      = sys;
  endtask

  task automatic cmpl(input logic [3:0] t);
    complete_valid = 1'b1;
    complete_tag   = t;
  endtask

  task automatic flush_pulse();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
  endtask

  initial begin
    // reset state
    #12;
    check("rst_cv", 32'(commit_valid), 32'd0);
    check("rst_cnt", 32'(count), 32'd0);
    check("rst_tag", 32'(alloc_tag), 32'd0);
    check("rst_halt", 32'(rob_halt), 32'd0);
    RESET = 1'b1;
    tick();

    // basic commit
    set_alloc(1'b1, 5'd3, 6'd40, 6'd3, 32'h0040_0000, 1'b0);
    check("b_tag", 32'(alloc_tag), 32'd0);
    tick();
    alloc_valid = 1'b0;
    cmpl(4'd0);
    check("b_cnt1", 32'(count), 32'd1);
    check("b_cv_e0", 32'(commit_valid), 32'd0);
    tick();
    complete_valid = 1'b0;
    check("b_cv_e1", 32'(commit_valid), 32'd0);
    tick();
    check("b_cv", 32'(commit_valid), 32'd1);
    check("b_arch", 32'(commit_arch), 32'd3);
    check("b_phys", 32'(commit_phys), 32'd40);
    check("b_pc", 32'(commit_pc), 32'h0040_0000);
    check("b_fv", 32'(free_valid), 32'd1);
    check("b_fp", 32'(free_phys), 32'd3);
    check("b_cnt0", 32'(count), 32'd0);
    tick();
    check("b_cv_off", 32'(commit_valid), 32'd0);
    check("b_fv_off", 32'(free_valid), 32'd0);
    check("b_hold", 32'(commit_arch), 32'd3);

    // out-of-order completion
    flush_pulse();
    check("o_tag0", 32'(alloc_tag), 32'd0);
    for (int i = 0; i < 3; i++) begin
      set_alloc(1'b1, 5'(5 + i), 6'(10 + i), 6'(20 + i),
                32'h1000 + 32'(4 * i), 1'b0);
      check("o_tag", 32'(alloc_tag), 32'(i));
      tick();
    end
    alloc_valid = 1'b0;
    cmpl(4'd2); tick();
    check("o_cv2", 32'(commit_valid), 32'd0);
    cmpl(4'd1); tick();
    check("o_cv1", 32'(commit_valid), 32'd0);
    cmpl(4'd0); tick();
    check("o_cv0", 32'(commit_valid), 32'd0);
    complete_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("o_cv", 32'(commit_valid), 32'd1);
      check("o_arch", 32'(commit_arch), 32'(5 + i));
      check("o_pc", 32'(commit_pc), 32'h1000 + 32'(4 * i));
      check("o_fp", 32'(free_phys), 32'(20 + i));
    end
    tick();
    check("o_end", 32'(commit_valid), 32'd0);
    check("o_cnt", 32'(count), 32'd0);

    // full and wrap-around (head = tail = 3)
    for (int i = 0; i < 16; i++) begin
      set_alloc(1'b1, 5'(i + 1), 6'(i), 6'(i + 32),
                32'h2000 + 32'(i), 1'(i & 1));
      check("f_tag", 32'(alloc_tag), 32'((3 + i) % 16));
      tick();
    end
    check("f_halt", 32'(rob_halt), 32'd1);
    check("f_cnt", 32'(count), 32'd16);
    check("f_tag17", 32'(alloc_tag), 32'd3);
    tick();
    alloc_valid = 1'b0;
    check("f_cnt17", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      cmpl(4'((3 + i) % 16));
      tick();
      check("f_dcnt", 32'(count), 32'(16 - i));
      if (i >= 1) begin
        check("f_cv", 32'(commit_valid), 32'd1);
        check("f_pc", 32'(commit_pc), 32'h2000 + 32'(i - 1));
      end
    end
    complete_valid = 1'b0;
    tick();
    check("f_last_pc", 32'(commit_pc), 32'h200F);
    check("f_last_sys", 32'(commit_sys), 32'd1);
    check("f_last_fp", 32'(free_phys), 32'd47);
    tick();
    check("f_cv_end", 32'(commit_valid), 32'd0);
    check("f_cnt_end", 32'(count), 32'd0);
    check("f_halt_end", 32'(rob_halt), 32'd0);

    // zero register
    set_alloc(1'b1, 5'd0, 6'd50, 6'd7, 32'h3000, 1'b0);
    check("z_tag", 32'(alloc_tag), 32'd3);
    tick();
    alloc_valid = 1'b0;
    cmpl(4'd3); tick();
    complete_valid = 1'b0;
    tick();
    check("z_cv", 32'(commit_valid), 32'd1);
    check("z_rw", 32'(commit_regwrite), 32'd1);
    check("z_fv", 32'(free_valid), 32'd0);
    check("z_phys", 32'(commit_phys), 32'd50);
    tick();

    // flush
    flush_pulse();
    for (int i = 0; i < 5; i++) begin
      set_alloc(1'b1, 5'(i + 1), 6'(i), 6'(i),
                32'h4000 + 32'(i), 1'b0);
      tick();
    end
    alloc_valid = 1'b0;
    cmpl(4'd1); tick();
    cmpl(4'd2); tick();
    complete_valid = 1'b0;
    check("l_cnt5", 32'(count), 32'd5);
    check("l_cv", 32'(commit_valid), 32'd0);
    FLUSH = 1'b1;
    set_alloc(1'b1, 5'd9, 6'd9, 6'd9, 32'h5555, 1'b0);
    tick();
    FLUSH = 1'b0;
    alloc_valid = 1'b0;
    check("l_cnt0", 32'(count), 32'd0);
    check("l_tag0", 32'(alloc_tag), 32'd0);
    check("l_cvf", 32'(commit_valid), 32'd0);
    set_alloc(1'b1, 5'd1, 6'd11, 6'd1, 32'h6000, 1'b0);
    tick();
    set_alloc(1'b1, 5'd2, 6'd12, 6'd2, 32'h6004, 1'b0);
    tick();
    alloc_valid = 1'b0;
    cmpl(4'd0); tick();
    complete_valid = 1'b0;
    tick();
    check("l_cv_new", 32'(commit_valid), 32'd1);
    check("l_pc_new", 32'(commit_pc), 32'h6000);
    tick();
    check("l_stale1", 32'(commit_valid), 32'd0);
    tick();
    check("l_stale2", 32'(commit_valid), 32'd0);
    check("l_cnt1", 32'(count), 32'd1);

    // reset mid-operation while commit_valid is high
    cmpl(4'd1); tick();
    complete_valid = 1'b0;
    tick();
    check("r_cv_pre", 32'(commit_valid), 32'd1);
    #3 RESET = 1'b0;
    #1;
    check("r_cv", 32'(commit_valid), 32'd0);
    check("r_pc", 32'(commit_pc), 32'd0);
    check("r_arch", 32'(commit_arch), 32'd0);
    check("r_phys", 32'(commit_phys), 32'd0);
    check("r_rw", 32'(commit_regwrite), 32'd0);
    check("r_fv", 32'(free_valid), 32'd0);
    check("r_fp", 32'(free_phys), 32'd0);
    check("r_cnt", 32'(count), 32'd0);
    check("r_tag", 32'(alloc_tag), 32'd0);
    check("r_halt", 32'(rob_halt), 32'd0);
    #2 RESET = 1'b1;
    tick();
    check("r_cv_post", 32'(commit_valid), 32'd0);
    check("r_cnt_post", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
